darkriscv_lsu_seq: RTL and testbench

//  Load/store sequencer between the core's load/store stage and the data bus.

---
 rtl/darkriscv_lsu_seq.sv | 185 ++++++++++++++++++
 tb/tb_darkriscv_lsu_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/darkriscv_lsu_seq.sv
// Load/store sequencer: one request becomes one byte-enabled bus cycle, with a DACK timeout.
// Strobes rise the edge after the request is seen; DONE/ERR pulse the edge after completion; HLT stalls the core throughout.
module darkriscv_lsu_seq #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_i,
   input  logic        res_i,
   input  logic        ld_req_i,
   input  logic        st_req_i,
   input  logic [2:0]  fct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] sdata_i,
   output logic [31:0] ldata_o,
   output logic        done_o,
   output logic        err_o,
   output logic        hlt_o,
   output logic [31:0] daddr_o,
   output logic [31:0] datao_o,
   output logic [3:0]  be_o,
   output logic        rd_o,
   output logic        wr_o,
   input  logic        dack_i,
   input  logic [31:0] datai_i
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_FIN, S_FAIL} state_t;

   localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  fct3_q, fct3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] ldata_q, ldata_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] daddr_q, daddr_d;
   logic [31:0] datao_q, datao_d;
   logic [3:0]  be_q, be_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;

   logic        req;
   logic        illegal;
   logic [3:0]  be_new;
   logic [31:0] datao_new;
   logic [31:0] lane;
   logic [31:0] ld_ext;
   logic [7:0]  cnt_inc;

   assign req     = ld_req_i | st_req_i;
   assign cnt_inc = cnt_q + 8'd1;

   // fct3[1:0] encodes the access size (00 byte, 01 half, 10 word); fct3[2] marks unsigned loads
   always_comb begin
      illegal = 1'b0;
      if (ld_req_i && st_req_i)                           illegal = 1'b1;
      if (fct3_i == 3'b011 || fct3_i[2:1] == 2'b11)       illegal = 1'b1;
      if (st_req_i && fct3_i[2])                          illegal = 1'b1;
      if (fct3_i[1:0] == 2'b01 && addr_i[0])              illegal = 1'b1;
      if (fct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00)   illegal = 1'b1;
   end

   always_comb begin
      be_new    = 4'b1111;
      datao_new = sdata_i;
      case (fct3_i[1:0])
         2'b00: begin
            be_new    = 4'b0001 << addr_i[1:0];
            datao_new = {4{sdata_i[7:0]}};
         end
         2'b01: begin
            be_new    = 4'b0011 << addr_i[1:0];
            datao_new = {2{sdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lane   = datai_i >> {off_q, 3'b000};
      ld_ext = datai_i;
      case (fct3_q)
         3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
         3'b100:  ld_ext = {24'd0, lane[7:0]};
         3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
         3'b101:  ld_ext = {16'd0, lane[15:0]};
         default: ld_ext = datai_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fct3_d  = fct3_q;
      off_d   = off_q;
      ldata_d = ldata_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      daddr_d = daddr_q;
      datao_d = datao_q;
      be_d    = be_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               fct3_d = fct3_i;
               off_d  = addr_i[1:0];
               if (illegal) begin
                  state_d = S_FAIL;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_BUS;
                  cnt_d   = 8'd0;
                  daddr_d = {addr_i[31:2], 2'b00};
                  be_d    = be_new;
                  datao_d = datao_new;
                  rd_d    = ld_req_i;
                  wr_d    = st_req_i;
               end
            end
         end
         S_BUS: begin
            if (dack_i) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = S_FIN;
               done_d  = 1'b1;
               if (rd_q) ldata_d = ld_ext;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TO_CNT) begin
                  rd_d    = 1'b0;
                  wr_d    = 1'b0;
                  state_d = S_FAIL;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (res_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         fct3_q  <= 3'd0;
         off_q   <= 2'd0;
         ldata_q <= 32'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         daddr_q <= 32'd0;
         datao_q <= 32'd0;
         be_q    <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fct3_q  <= fct3_d;
         off_q   <= off_d;
         ldata_q <= ldata_d;
         done_q  <= done_d;
         err_q   <= err_d;
         daddr_q <= daddr_d;
         datao_q <= datao_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign hlt_o   = ((state_q == S_IDLE) && req) || (state_q == S_BUS);
   assign ldata_o = ldata_q;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign daddr_o = daddr_q;
   assign datao_o = datao_q;
   assign be_o    = be_q;
   assign rd_o    = rd_q;
   assign wr_o    = wr_q;

endmodule

// File: tb/tb_darkriscv_lsu_seq.sv
// Bench for darkriscv_lsu_seq: directed corner cases then random transactions vs. a size/offset reference model.
module tb_darkriscv_lsu_seq;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        res;
   logic        ld_req, st_req;
   logic [2:0]  fct3;
   logic [31:0] addr, sdata;
   logic [31:0] ldata;
   logic        done, err, hlt;
   logic [31:0] daddr, datao;
   logic [3:0]  be;
   logic        rd, wr;
   logic        dack;
   logic [31:0] datai;

   int n_chk = 0;
   int n_bad = 0;
   logic [31:0] ldata_m = 32'd0;

   darkriscv_lsu_seq #(.TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .res_i(res), .ld_req_i(ld_req), .st_req_i(st_req),
      .fct3_i(fct3), .addr_i(addr), .sdata_i(sdata), .ldata_o(ldata),
      .done_o(done), .err_o(err), .hlt_o(hlt), .daddr_o(daddr), .datao_o(datao),
      .be_o(be), .rd_o(rd), .wr_o(wr), .dack_i(dack), .datai_i(datai)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One transaction, starting at a negedge. dly = BUS cycles without DACK before DACK arrives.
   task automatic txn(input bit l, input bit s, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input logic [31:0] di, input int dly);
      int          sz;
      int          o;
      bit          bad;
      logic [3:0]  be_e;
      logic [31:0] do_e, ld_e, mask;
      sz  = 1 << (f3 % 4);
      o   = a % 4;
      bad = (l && s) || f3 == 3 || f3 == 6 || f3 == 7 || (s && f3 >= 4) || (a % sz != 0);
      be_e = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << o);
      do_e = (sz == 1) ? sd[7:0] * 32'h01010101 : (sz == 2) ? sd[15:0] * 32'h00010001 : sd;
      ld_e = di;
      if (sz < 4) begin
         mask = (32'd1 << (8 * sz)) - 32'd1;
         ld_e = (di >> (8 * o)) & mask;
         if (f3 < 4 && ld_e[8 * sz - 1]) ld_e = ld_e | ~mask;
      end

      ld_req = l; st_req = s; fct3 = f3; addr = a; sdata = sd; dack = 1'b0; datai = $urandom;
      #1 check("hlt_req", hlt, 1);
      @(posedge clk); @(negedge clk);
      if (bad) begin
         check("err_illegal", err, 1);
         check("rd_illegal", rd, 0);
         check("wr_illegal", wr, 0);
         check("hlt_fail", hlt, 0);
         check("ldata_keep", ldata, ldata_m);
      end else begin
         for (int k = 0; k <= TIMEOUT; k++) begin
            check("rd_bus", rd, l);
            check("wr_bus", wr, s);
            check("be_bus", be, be_e);
            check("daddr_bus", daddr, {a[31:2], 2'b00});
            if (s) check("datao_bus", datao, do_e);
            check("hlt_bus", hlt, 1);
            dack  = (k == dly);
            datai = (k == dly) ? di : $urandom;
            @(posedge clk); @(negedge clk);
            dack = 1'b0;
            if (k == dly) begin
               if (l) ldata_m = ld_e;
               check("done_pulse", done, 1);
               check("err_ok", err, 0);
               check("strobe_off", rd | wr, 0);
               check("hlt_fin", hlt, 0);
               check("ldata", ldata, ldata_m);
               break;
            end
            if (k + 1 == TIMEOUT) begin
               check("err_timeout", err, 1);
               check("done_timeout", done, 0);
               check("strobe_to", rd | wr, 0);
               check("hlt_to", hlt, 0);
               check("ldata_to", ldata, ldata_m);
               break;
            end
         end
      end
      ld_req = 1'b0; st_req = 1'b0;
      @(negedge clk);
      check("done_clr", done, 0);
      check("err_clr", err, 0);
      check("hlt_idle", hlt, 0);
   endtask

   initial begin
      res = 1'b1; ld_req = 1'b0; st_req = 1'b0; fct3 = 3'd0; addr = 32'd0;
      sdata = 32'd0; dack = 1'b0; datai = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_ldata", ldata, 0);
      check("rst_pulses", {30'd0, done, err}, 0);
      check("rst_strobes", {30'd0, rd, wr}, 0);
      check("rst_bus", daddr | datao | {28'd0, be}, 0);
      res = 1'b0;
      @(negedge clk);
      check("idle_hlt", hlt, 0);

      txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80000000, 0);   // LB sign-extend, top lane
      check("t1_ldata", ldata, 32'hFFFFFF80);
      txn(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3);   // SH upper half
      txn(1, 0, 3'b010, 32'h301, 32'h0, 32'h0, 0);          // misaligned LW
      check("t3_ldata", ldata, 32'hFFFFFF80);
      txn(1, 0, 3'b101, 32'h2, 32'h0, 32'h0, 1000);         // LHU timeout
      txn(1, 1, 3'b010, 32'h0, 32'h0, 32'h0, 0);            // both requests

      // reset while in BUS
      ld_req = 1'b1; fct3 = 3'b010; addr = 32'h10;
      @(posedge clk); @(negedge clk);
      check("rb_rd", rd, 1);
      res = 1'b1; ld_req = 1'b0;
      @(posedge clk); @(negedge clk);
      ldata_m = 32'd0;
      check("rb_rd_drop", rd, 0);
      check("rb_pulses", {30'd0, done, err}, 0);
      res = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rb_idle_pulses", {30'd0, done, err}, 0);
      check("rb_idle_rd", rd, 0);
      check("rb_ldata", ldata, 0);

      for (int i = 0; i < 300; i++) begin
         int r;
         logic [31:0] a;
         r = $urandom_range(0, 9);
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         txn(r == 0 || r < 5, r == 0 || r >= 5, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
             $urandom_range(0, TIMEOUT + 3));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
